// File: rtl/uart_tx_dump_pkg.sv
// Shared UART definitions: frame state encoding, data width, default bit period.
// Used by the dump transmitter and its baud generator.
package uart_tx_dump_pkg;

  localparam int unsigned UART_DATA_W      = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 5208;  // 50 MHz / 9600 baud
  localparam int unsigned BAUD_CNT_W       = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StStart,
    StData,
    StPar,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable down-counter producing a one-cycle tick at each UART bit boundary.
// Reloads itself after reaching zero while enabled; idles at zero otherwise.
module uart_baud_gen #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [CntW-1:0] reload_i,
  output logic            tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    cnt_d = '0;
    if (load_i) begin
      cnt_d = reload_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? reload_i : cnt_q - CntW'(1);
    end
    // Registered so the tick lines up with the cycle the counter sits at zero.
    tick_d = (load_i || en_i) && (cnt_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx_dump.sv
// Reads a block of bytes from configuration RAM and sends each one as a UART frame.
// Define UART_TX_PARITY_EN for an even-parity bit (8E1); default build is 8N1.
module uart_tx_dump
  import uart_tx_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dump_req,
  input  logic [ADDR_W-1:0]      dump_addr,
  input  logic [ADDR_W:0]        dump_len,
  input  logic                   abort,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [UART_DATA_W-1:0] rd_data,
  output logic                   tx,
  output logic                   baud_tick,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned BitCntW = $clog2(UART_DATA_W);
  localparam logic [BAUD_CNT_W-1:0] BaudReload = BAUD_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(UART_DATA_W - 1);

  uart_state_e            state_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [ADDR_W:0]        remain_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic [BitCntW-1:0]     bit_cnt_q;
  logic                   tx_q;
  logic                   rd_en_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  logic tick;
  logic baud_load;
  logic baud_en;

  assign baud_load = (state_q == StLatch);
  assign baud_en   = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StPar)   || (state_q == StStop);

  uart_baud_gen #(
    .CntW (BAUD_CNT_W)
  ) u_baud_gen (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (baud_load),
    .en_i     (baud_en),
    .reload_i (BaudReload),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      remain_q  <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (dump_req) begin
            addr_q   <= dump_addr;
            remain_q <= dump_len;
            if (dump_len == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          state_q <= StLatch;
        end
        StLatch: begin
          shift_q <= rd_data;
`ifdef UART_TX_PARITY_EN
          par_q   <= ^rd_data;
`endif
          tx_q    <= 1'b0;
          state_q <= StStart;
        end
        StStart: begin
          if (tick) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (tick) begin
            if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= StPar;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StPar: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (tick) begin
            remain_q <= remain_q - (ADDR_W + 1)'(1);
            addr_q   <= addr_q + ADDR_W'(1);
            // abort is only honoured here so a frame is never cut short.
            if (remain_q == (ADDR_W + 1)'(1) || abort) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= StFetch;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = addr_q;
  assign tx        = tx_q;
  assign baud_tick = tick;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_tx_dump.sv
// Scoreboard bench for uart_tx_dump at 4 clocks per bit; decodes tx cycle by cycle.
// Frame length follows UART_TX_PARITY_EN so the bench covers both builds.
module tb_uart_tx_dump;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dump_req;
  logic [7:0] dump_addr;
  logic [8:0] dump_len;
  logic       abort;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       tx;
  logic       baud_tick;
  logic       busy;
  logic       done;

  logic [7:0] ram [256];
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_addr[$];
  int         n_total = 0;
  int         n_bad   = 0;

  uart_tx_dump #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dump_req  (dump_req),
    .dump_addr (dump_addr),
    .dump_len  (dump_len),
    .abort     (abort),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tx        (tx),
    .baud_tick (baud_tick),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // RAM read port: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_dump(input logic [7:0] addr, input logic [8:0] len, input int abort_cyc,
                          input int frames, input int busy_req_cyc);
    int         done_at, tx_first, rd_first, ticks, busy_cnt, quiet, fs, k, idx, exp_done;
    logic       tx_prev, in_frame;
    logic [7:0] rx, a, eb, ea;
    for (int i = 0; i < frames; i++) begin
      a = addr + 8'(i);
      exp_addr.push_back(a);
      exp_bytes.push_back(ram[a]);
    end
    done_at = -1; tx_first = -1; rd_first = -1; ticks = 0; busy_cnt = 0; quiet = 0;
    fs = 0; tx_prev = 1'b1; in_frame = 1'b0; rx = '0;
    exp_done = (len == 0) ? 1 : 1 + frames * (FB * CPB + 2);

    @(negedge clk);
    dump_addr = addr;
    dump_len  = len;
    dump_req  = 1'b1;
    for (int c = 1; c <= 2000 && done_at < 0; c++) begin
      @(negedge clk);
      if (rd_en) begin
        if (rd_first < 0) rd_first = c;
        if (exp_addr.size() > 0) begin
          ea = exp_addr.pop_front();
          chk("rd_addr", rd_addr, ea);
        end else begin
          chk("rd_en_extra", 1, 0);
        end
      end
      if (!tx && tx_first < 0) tx_first = c;
      if (baud_tick) ticks++;
      if (!in_frame && tx_prev && !tx) begin
        in_frame = 1'b1;
        fs = c;
      end
      if (in_frame) begin
        k = c - fs;
        if (k % CPB == CPB / 2) begin
          idx = k / CPB;
          if (idx == 0) begin
            chk("start_bit", tx, 0);
          end else if (idx <= 8) begin
            rx[idx-1] = tx;
          end else if (idx < FB - 1) begin
            chk("parity_bit", tx, ^rx);
          end else begin
            chk("stop_bit", tx, 1);
            if (exp_bytes.size() > 0) begin
              eb = exp_bytes.pop_front();
              chk("rx_byte", rx, eb);
            end else begin
              chk("rx_extra", 1, 0);
            end
            in_frame = 1'b0;
          end
        end
      end
      tx_prev = tx;
      if (done) begin
        done_at = c;
        chk("busy_at_done", busy, 0);
      end else if (busy) begin
        busy_cnt++;
      end
      dump_req = (c == busy_req_cyc);
      if (c == busy_req_cyc) begin
        dump_addr = 8'h33;
        dump_len  = 9'd5;
      end
      abort = (abort_cyc > 0 && c >= abort_cyc);
    end
    dump_req = 1'b0;
    abort    = 1'b0;

    if (done_at < 0) chk("done_timeout", 0, 1);
    else             chk("done_cycle", done_at, exp_done);
    chk("rd_en_first", rd_first, (len != 0) ? 1 : -1);
    chk("tx_fall", tx_first, (len != 0) ? 3 : -1);
    chk("busy_cycles", busy_cnt, (len != 0) ? exp_done - 1 : 0);
    chk("baud_ticks", ticks, frames * FB);

    repeat (50) begin
      @(negedge clk);
      if (rd_en || !tx || done || busy) quiet++;
    end
    chk("post_quiet", quiet, 0);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("addrs_left", exp_addr.size(), 0);
    exp_bytes.delete();
    exp_addr.delete();
  endtask

  initial begin
    int quiet;
    rst_n     = 1'b0;
    dump_req  = 1'b0;
    dump_addr = '0;
    dump_len  = '0;
    abort     = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 11);
    ram[8'h10] = 8'hA5;
    ram[8'hFE] = 8'h3C;
    ram[8'hFF] = 8'hC3;
    ram[8'h00] = 8'h5E;
    ram[8'h40] = 8'h81;
    ram[8'h41] = 8'h7E;
    ram[8'h60] = 8'h07;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_baud_tick", baud_tick, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_dump(8'h10, 9'd1, -1, 1, 20);   // single byte, request while busy ignored
    run_dump(8'hFE, 9'd3, -1, 3, -1);   // address wrap
    run_dump(8'h80, 9'd0, -1, 0, -1);   // zero length
    run_dump(8'h40, 9'd5, 60, 2, -1);   // abort during second frame
    run_dump(8'h60, 9'd1, -1, 1, -1);   // 0x07: parity bit 1 when enabled

    // Reset while shifting data bits.
    @(negedge clk);
    dump_addr = 8'h20;
    dump_len  = 9'd2;
    dump_req  = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (60) begin
      @(negedge clk);
      if (rd_en || !tx || done || busy || baud_tick) quiet++;
    end
    chk("post_reset_quiet", quiet, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
